activate_dense_bp_reg: RTL and testbench

- Backward-path pipeline register between the activation-backprop stage and the dense-backprop stage.
- Carries the gradient bundle in the opposite direction to the forward dense→activate delay register.
- Unlike the forward register, it is elastic: a valid/ready handshake on both sides, plus a 2-entry skid buffer so the dense-backprop stage can stall without dropping or duplicating gradients.

---
 rtl/nb_pipe_pkg.sv | 22 ++
 rtl/bp_skid_buf.sv | 97 +++++++++
 rtl/activate_dense_bp_reg.sv | 84 ++++++++
 tb/tb_activate_dense_bp_reg.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nb_pipe_pkg.sv
// Shared types and helpers for the network backward-path pipeline registers.
package nb_pipe_pkg;

    localparam int unsigned INDEX_W = 32;

    // Occupancy of a two-slot elastic buffer.
    typedef enum logic [1:0] {
        BP_EMPTY = 2'd0,
        BP_ONE   = 2'd1,
        BP_FULL  = 2'd2
    } bp_state_t;

    // Width of the packed gradient bundle: grad, x, w, act_type, layer index, row index, is_update.
    function automatic int unsigned bp_bundle_width(
        input int unsigned size,
        input int unsigned data_size,
        input int unsigned act_type_size
    );
        return 3 * data_size * size + act_type_size + 2 * INDEX_W + 1;
    endfunction

endpackage

// File: rtl/bp_skid_buf.sv
// Generic two-slot elastic buffer (main + skid) with valid/ready on both sides.
// The ready output is decoded from registered state only, so there is no
// combinational path from the downstream ready to the upstream ready.
module bp_skid_buf
    import nb_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    bp_state_t        r_state;
    bp_state_t        w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_push;
    logic             w_pop;
    logic             w_main_from_in;
    logic             w_main_from_skid;
    logic             w_skid_from_in;

    assign w_push = i_valid & o_ready;
    assign w_pop  = o_valid & i_ready;

    // State register; reset wins over any transfer in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= BP_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and slot load selects.
    always_comb begin
        w_state_nxt      = r_state;
        w_main_from_in   = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_from_in   = 1'b0;
        case (r_state)
            BP_EMPTY: begin
                if (w_push) begin
                    w_state_nxt    = BP_ONE;
                    w_main_from_in = 1'b1;
                end
            end
            BP_ONE: begin
                if (w_push && w_pop) begin
                    w_main_from_in = 1'b1;
                end else if (w_push) begin
                    w_state_nxt    = BP_FULL;
                    w_skid_from_in = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = BP_EMPTY;
                end
            end
            BP_FULL: begin
                if (w_pop) begin
                    w_state_nxt      = BP_ONE;
                    w_main_from_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = BP_EMPTY;
            end
        endcase
    end

    // Data slots; cleared on reset so the outputs read zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_main_from_in) begin
                r_main <= i_data;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_skid_from_in) begin
                r_skid <= i_data;
            end
        end
    end

    assign o_valid = (r_state != BP_EMPTY);
    assign o_ready = (r_state != BP_FULL);
    assign o_data  = r_main;

endmodule

// File: rtl/activate_dense_bp_reg.sv
// Elastic backward-path register between activation backprop and dense backprop.
// Packs the gradient bundle into one vector for a two-slot skid buffer.
// Optional statistics counters are enabled by defining BP_REG_STATS_EN.
module activate_dense_bp_reg
    import nb_pipe_pkg::*;
#(
    parameter int unsigned size          = 3,
    parameter int unsigned data_size     = 16,
    parameter int unsigned act_type_size = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [data_size*size-1:0]      grad,
    input  logic [data_size*size-1:0]      x,
    input  logic [data_size*size-1:0]      w,
    input  logic [act_type_size-1:0]       act_type,
    input  logic [INDEX_W-1:0]             w_layer_index,
    input  logic [INDEX_W-1:0]             w_row_index,
    input  logic                           is_update,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [data_size*size-1:0]      grad_out,
    output logic [data_size*size-1:0]      x_out,
    output logic [data_size*size-1:0]      w_out,
    output logic [act_type_size-1:0]       act_type_out,
    output logic [INDEX_W-1:0]             w_layer_index_out,
    output logic [INDEX_W-1:0]             w_row_index_out,
    output logic                           is_update_out
`ifdef BP_REG_STATS_EN
    ,
    output logic [31:0]                    stall_count,
    output logic [31:0]                    xfer_count
`endif
);

    localparam int unsigned BUNDLE_W = bp_bundle_width(size, data_size, act_type_size);

    logic [BUNDLE_W-1:0] w_bundle_in;
    logic [BUNDLE_W-1:0] w_bundle_out;

    assign w_bundle_in = {grad, x, w, act_type, w_layer_index, w_row_index, is_update};

    bp_skid_buf #(
        .WIDTH (BUNDLE_W)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_bundle_in),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_bundle_out)
    );

    assign {grad_out, x_out, w_out, act_type_out,
            w_layer_index_out, w_row_index_out, is_update_out} = w_bundle_out;

`ifdef BP_REG_STATS_EN
    logic [31:0] r_stall_count;
    logic [31:0] r_xfer_count;

    // Saturating counters of stalled cycles and completed output transfers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
            r_xfer_count  <= '0;
        end else begin
            if (out_valid && !out_ready && (r_stall_count != 32'hFFFF_FFFF)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            if (out_valid && out_ready && (r_xfer_count != 32'hFFFF_FFFF)) begin
                r_xfer_count <= r_xfer_count + 32'd1;
            end
        end
    end

    assign stall_count = r_stall_count;
    assign xfer_count  = r_xfer_count;
`endif

endmodule

// File: tb/tb_activate_dense_bp_reg.sv
// Self-checking bench for activate_dense_bp_reg: directed scenarios plus
// randomized valid/ready traffic against a capacity-2 FIFO reference model.
// Define BP_REG_STATS_EN to also check the statistics counters.
module tb_activate_dense_bp_reg;

    localparam int unsigned SIZE = 3;
    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 4;
    localparam int unsigned VW   = SIZE * DW;

    typedef struct packed {
        logic [VW-1:0] grad;
        logic [VW-1:0] x;
        logic [VW-1:0] w;
        logic [AW-1:0] act;
        logic [31:0]   layer;
        logic [31:0]   row;
        logic          upd;
    } bnd_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    bnd_t          cur;
    logic [VW-1:0] grad_out;
    logic [VW-1:0] x_out;
    logic [VW-1:0] w_out;
    logic [AW-1:0] act_type_out;
    logic [31:0]   w_layer_index_out;
    logic [31:0]   w_row_index_out;
    logic          is_update_out;
`ifdef BP_REG_STATS_EN
    logic [31:0]   stall_count;
    logic [31:0]   xfer_count;
    logic [31:0]   stall_m;
    logic [31:0]   xfer_m;
`endif

    bnd_t q[$];
    int   chk_cnt;
    int   err_cnt;

    always #5 clk = ~clk;

    activate_dense_bp_reg #(
        .size          (SIZE),
        .data_size     (DW),
        .act_type_size (AW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .grad              (cur.grad),
        .x                 (cur.x),
        .w                 (cur.w),
        .act_type          (cur.act),
        .w_layer_index     (cur.layer),
        .w_row_index       (cur.row),
        .is_update         (cur.upd),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .grad_out          (grad_out),
        .x_out             (x_out),
        .w_out             (w_out),
        .act_type_out      (act_type_out),
        .w_layer_index_out (w_layer_index_out),
        .w_row_index_out   (w_row_index_out),
        .is_update_out     (is_update_out)
`ifdef BP_REG_STATS_EN
        ,
        .stall_count       (stall_count),
        .xfer_count        (xfer_count)
`endif
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bnd_t rand_bnd(input logic [31:0] row);
        bnd_t b;
        b.grad  = VW'({$urandom(), $urandom()});
        b.x     = VW'({$urandom(), $urandom()});
        b.w     = VW'({$urandom(), $urandom()});
        b.act   = AW'($urandom());
        b.layer = $urandom();
        b.row   = row;
        b.upd   = 1'($urandom());
        return b;
    endfunction

    task automatic check_head(input string pfx);
        check({pfx, "_grad"},  64'(grad_out),          64'(q[0].grad));
        check({pfx, "_x"},     64'(x_out),             64'(q[0].x));
        check({pfx, "_w"},     64'(w_out),             64'(q[0].w));
        check({pfx, "_act"},   64'(act_type_out),      64'(q[0].act));
        check({pfx, "_layer"}, 64'(w_layer_index_out), 64'(q[0].layer));
        check({pfx, "_row"},   64'(w_row_index_out),   64'(q[0].row));
        check({pfx, "_upd"},   64'(is_update_out),     64'(q[0].upd));
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_valid"}, 64'(out_valid), 64'd0);
        check({pfx, "_ready"}, 64'(in_ready),  64'd1);
        check({pfx, "_zero"},  64'(|{grad_out, x_out, w_out, act_type_out,
                                      w_layer_index_out, w_row_index_out, is_update_out}), 64'd0);
`ifdef BP_REG_STATS_EN
        check({pfx, "_stall0"}, 64'(stall_count), 64'd0);
        check({pfx, "_xfer0"},  64'(xfer_count),  64'd0);
`endif
    endtask

    // One clock: compare outputs at the falling edge, advance the model at the rising edge.
    task automatic step();
        logic push;
        logic pop;
        logic stall;
        @(negedge clk);
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        check("in_ready",  64'(in_ready),  64'(q.size() < 2));
        if (q.size() != 0) check_head("out");
`ifdef BP_REG_STATS_EN
        check("stall_count", 64'(stall_count), 64'(stall_m));
        check("xfer_count",  64'(xfer_count),  64'(xfer_m));
`endif
        push  = in_valid && (q.size() < 2);
        pop   = out_ready && (q.size() != 0);
        stall = !out_ready && (q.size() != 0);
        @(posedge clk);
        #1;
        if (reset) begin
            q.delete();
`ifdef BP_REG_STATS_EN
            stall_m = '0;
            xfer_m  = '0;
`endif
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(cur);
`ifdef BP_REG_STATS_EN
            if (stall && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 32'd1;
            if (pop && xfer_m != 32'hFFFF_FFFF) xfer_m = xfer_m + 32'd1;
`endif
        end
        if (stall && pop) check("model_sanity", 64'd1, 64'd0);
    endtask

    initial begin
        chk_cnt   = 0;
        err_cnt   = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cur       = '0;
`ifdef BP_REG_STATS_EN
        stall_m   = '0;
        xfer_m    = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_zero("reset");

        // Pass-through of a single bundle.
        out_ready = 1'b1;
        cur       = rand_bnd(32'd5);
        cur.grad  = 48'h0001_0002_0003;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        check("pt_valid", 64'(out_valid),       64'd1);
        check("pt_grad",  64'(grad_out),        64'h0001_0002_0003);
        check("pt_row",   64'(w_row_index_out), 64'd5);
        check("pt_ready", 64'(in_ready),        64'd1);
        step();

        // Back-to-back streaming of rows 0..7.
        for (int i = 0; i < 8; i++) begin
            cur      = rand_bnd(32'(i));
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step();

        // Stall fill, then drain.
        out_ready = 1'b0;
        for (int i = 10; i < 12; i++) begin
            cur      = rand_bnd(32'(i));
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check("fill_ready", 64'(in_ready),        64'd0);
        check("fill_row",   64'(w_row_index_out), 64'd10);
        step();
        check("fill_hold",  64'(w_row_index_out), 64'd10);
        out_ready = 1'b1;
        step();
        check("drain_ready", 64'(in_ready),        64'd1);
        check("drain_row",   64'(w_row_index_out), 64'd11);
        step();
        check("drain_empty", 64'(out_valid), 64'd0);

        // Simultaneous push and pop while holding one entry.
        out_ready = 1'b0;
        cur       = rand_bnd(32'd20);
        in_valid  = 1'b1;
        step();
        out_ready = 1'b1;
        cur       = rand_bnd(32'd21);
        step();
        in_valid = 1'b0;
        check("pp_valid", 64'(out_valid),       64'd1);
        check("pp_row",   64'(w_row_index_out), 64'd21);
        check("pp_ready", 64'(in_ready),        64'd1);
        step();

        // Mid-stream reset discards both slots, even with a push offered.
        out_ready = 1'b0;
        for (int i = 30; i < 32; i++) begin
            cur      = rand_bnd(32'(i));
            in_valid = 1'b1;
            step();
        end
        reset     = 1'b1;
        out_ready = 1'b1;
        cur       = rand_bnd(32'd99);
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        check_zero("midrst");
        cur      = rand_bnd(32'd32);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("midrst_row", 64'(w_row_index_out), 64'd32);
        step();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cur       = rand_bnd($urandom());
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
